// File: rtl/kp_pkg.sv
// kp_pkg: shared types and width helper for the keypad matrix scanner
package kp_pkg;
   typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} kp_state_e;
   typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_res_e;
   function automatic int kw(input int rows, input int cols);
      return rows * cols > 1 ? $clog2(rows * cols) : 1;
   endfunction
endpackage

// File: rtl/kp_col_driver.sv
// kp_col_driver: column slot timer, one-hot column drive and sample/frame-end strobes
module kp_col_driver #(
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [COLS-1:0]         scan_out,
   output logic [$clog2(COLS)-1:0] col_idx,
   output logic                    sample_stb,
   output logic                    frame_end
);
   localparam int TW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(COLS);
   logic [TW-1:0]   timer;
   logic [COLS-1:0] one_hot;
   always_ff @(posedge clk) begin
      if (rst) begin
         timer   <= '0;
         col_idx <= '0;
      end else begin
         timer <= sample_stb ? '0 : timer + 1'b1;
         if (sample_stb) col_idx <= col_idx == CW'(COLS - 1) ? '0 : col_idx + 1'b1;
      end
   end
   // rows are sampled in the last cycle of a slot to give the lines time to settle
   always_comb begin
      sample_stb = timer == TW'(SCAN_DIV - 1);
      frame_end  = sample_stb && col_idx == CW'(COLS - 1);
      one_hot    = COLS'(1) << col_idx;
      scan_out   = ACTIVE_LOW != 0 ? ~one_hot : one_hot;
   end
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: column-scanned keypad with frame-level debounce, one pulse per accepted press
module keypad_matrix_scanner
   import kp_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int DEBOUNCE   = 4,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ROWS-1:0]            scan_in,
   output logic [COLS-1:0]            scan_out,
   output logic [kw(ROWS, COLS)-1:0]  key_code,
   output logic                       key_valid,
   output logic                       key_held,
   output logic                       multi_err
);
   localparam int KW = kw(ROWS, COLS);
   localparam int CW = $clog2(COLS);
   localparam int SW = $clog2(DEBOUNCE + 1);
   logic [CW-1:0]   col_idx;
   logic            sample_stb, frame_end;
   logic [ROWS-1:0] pressed;
   logic [1:0]      col_cnt, acc_cnt, tot_cnt;
   logic [2:0]      sum_cnt;
   logic [KW-1:0]   col_code, acc_code, tot_code;
   frame_res_e      res;
   kp_state_e       state, state_n;
   logic [KW-1:0]   cand, cand_n, code_n;
   logic [SW-1:0]   stab, stab_n, stab_inc;
   logic            valid_n, held_n, merr_n, single, match;
   kp_col_driver #(.COLS(COLS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(ACTIVE_LOW)) u_col (
      .clk(clk), .rst(rst), .scan_out(scan_out), .col_idx(col_idx),
      .sample_stb(sample_stb), .frame_end(frame_end)
   );
   // key count saturates at 2: anything beyond "more than one" is just multi
   always_comb begin
      pressed  = ACTIVE_LOW != 0 ? ~scan_in : scan_in;
      col_cnt  = '0;
      col_code = '0;
      for (int r = ROWS - 1; r >= 0; r--)
         if (pressed[r]) begin
            col_cnt  = col_cnt == 2'd2 ? col_cnt : col_cnt + 1'b1;
            col_code = KW'(r * COLS + int'(col_idx));
         end
      sum_cnt  = {1'b0, acc_cnt} + {1'b0, col_cnt};
      tot_cnt  = sum_cnt >= 3'd2 ? 2'd2 : sum_cnt[1:0];
      tot_code = acc_cnt != 2'd0 ? acc_code : col_code;
      res      = tot_cnt == 2'd0 ? NONE : (tot_cnt == 2'd1 ? SINGLE : MULTI);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt  <= '0;
         acc_code <= '0;
      end else if (sample_stb) begin
         acc_cnt  <= frame_end ? '0 : tot_cnt;
         acc_code <= frame_end ? '0 : tot_code;
      end
   end
   always_comb begin
      single   = res == SINGLE;
      match    = single && tot_code == cand;
      stab_inc = stab == SW'(DEBOUNCE) ? stab : stab + 1'b1;
      state_n  = state;
      cand_n   = cand;
      stab_n   = stab;
      code_n   = key_code;
      valid_n  = 1'b0;
      held_n   = key_held;
      merr_n   = multi_err;
      if (frame_end) begin
         merr_n = res == MULTI;
         case (state)
            IDLE: if (single) begin
               cand_n  = tot_code;
               stab_n  = SW'(1);
               state_n = DB_PRESS;
               if (DEBOUNCE == 1) begin
                  state_n = PRESSED;
                  code_n  = tot_code;
                  valid_n = 1'b1;
                  held_n  = 1'b1;
               end
            end
            DB_PRESS: if (match) begin
               stab_n = stab_inc;
               if (stab_inc == SW'(DEBOUNCE)) begin
                  state_n = PRESSED;
                  code_n  = cand;
                  valid_n = 1'b1;
                  held_n  = 1'b1;
               end
            end else if (single) begin
               cand_n = tot_code;
               stab_n = SW'(1);
            end else begin
               state_n = IDLE;
               stab_n  = '0;
            end
            PRESSED: if (!match) begin
               state_n = DB_RELEASE;
               stab_n  = SW'(1);
               if (DEBOUNCE == 1) begin
                  state_n = IDLE;
                  held_n  = 1'b0;
                  stab_n  = '0;
               end
            end
            DB_RELEASE: if (match) begin
               state_n = PRESSED;
               stab_n  = '0;
            end else begin
               stab_n = stab_inc;
               if (stab_inc == SW'(DEBOUNCE)) begin
                  state_n = IDLE;
                  held_n  = 1'b0;
                  stab_n  = '0;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cand      <= '0;
         stab      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         state     <= state_n;
         cand      <= cand_n;
         stab      <= stab_n;
         key_code  <= code_n;
         key_valid <= valid_n;
         key_held  <= held_n;
         multi_err <= merr_n;
      end
   end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: frame-by-frame directed vectors against a 4x4 active-low key matrix model
module tb_keypad_matrix_scanner;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] scan_in, scan_out, key_code;
   logic       key_valid, key_held, multi_err;
   logic [15:0] keys;
   int n_cmp = 0, n_err = 0, pulses = 0;
   typedef struct {
      logic [15:0] keys;
      int pulses;
      int valid;
      int held;
      int merr;
      int code;
   } vec_t;
   vec_t tv[$];
   keypad_matrix_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2), .ACTIVE_LOW(1)) dut (
      .clk(clk), .rst(rst), .scan_in(scan_in), .scan_out(scan_out),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_err(multi_err)
   );
   always #5 clk = ~clk;
   // a pressed key pulls its row low while its column is driven low
   always_comb begin
      scan_in = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r * 4 + c] && !scan_out[c]) scan_in[r] = 1'b0;
   end
   always @(negedge clk) if (key_valid) pulses++;
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic run_frames(input int n);
      repeat (16 * n) @(posedge clk);
      @(negedge clk);
      #1;
   endtask
   task automatic add(input logic [15:0] k, input int p, input int v, input int h, input int m, input int c);
      tv.push_back('{k, p, v, h, m, c});
   endtask
   task automatic chk_outs(input string tag, input int p, input int v, input int h, input int m, input int c);
      chk({tag, " pulses"}, pulses, p);
      chk({tag, " key_valid"}, int'(key_valid), v);
      chk({tag, " key_held"}, int'(key_held), h);
      chk({tag, " multi_err"}, int'(multi_err), m);
      chk({tag, " key_code"}, int'(key_code), c);
   endtask
   initial begin
      logic [3:0] e;
      add(16'h0200, 0, 0, 0, 0, 0);
      add(16'h0200, 1, 1, 1, 0, 9);
      add(16'h0200, 1, 0, 1, 0, 9);
      add(16'h0000, 1, 0, 1, 0, 9);
      add(16'h0000, 1, 0, 0, 0, 9);
      for (int i = 0; i < 4; i++) begin
         add(16'h0200, 1, 0, 0, 0, 9);
         add(16'h0000, 1, 0, 0, 0, 9);
      end
      add(16'h0200, 1, 0, 0, 0, 9);
      add(16'h0200, 2, 1, 1, 0, 9);
      for (int i = 0; i < 8; i++) add(16'h0200, 2, 0, 1, 0, 9);
      add(16'h0000, 2, 0, 1, 0, 9);
      add(16'h0000, 2, 0, 0, 0, 9);
      add(16'h0200, 2, 0, 0, 0, 9);
      add(16'h0200, 3, 1, 1, 0, 9);
      add(16'h0000, 3, 0, 1, 0, 9);
      add(16'h0000, 3, 0, 0, 0, 9);
      for (int i = 0; i < 3; i++) add(16'h8001, 3, 0, 0, 1, 9);
      add(16'h0000, 3, 0, 0, 0, 9);
      add(16'h0020, 3, 0, 0, 0, 9);
      add(16'h0020, 4, 1, 1, 0, 5);
      add(16'h0040, 4, 0, 1, 0, 5);
      add(16'h0040, 4, 0, 0, 0, 5);
      add(16'h0040, 4, 0, 0, 0, 5);
      add(16'h0040, 5, 1, 1, 0, 6);
      add(16'h0000, 5, 0, 1, 0, 6);
      add(16'h0040, 5, 0, 1, 0, 6);
      add(16'h0000, 5, 0, 1, 0, 6);
      add(16'h0000, 5, 0, 0, 0, 6);
      add(16'h0008, 5, 0, 0, 0, 6);
      add(16'h1000, 5, 0, 0, 0, 6);
      add(16'h1000, 6, 1, 1, 0, 12);
      add(16'h0000, 6, 0, 1, 0, 12);
      add(16'h0000, 6, 0, 0, 0, 12);
      keys = '0;
      rst  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset scan_out", int'(scan_out), 4'b1110);
      chk_outs("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) begin
            @(posedge clk);
            @(negedge clk);
            #1;
         end
         e = ~(4'b0001 << (i / 4));
         chk($sformatf("scan cyc%0d", i), int'(scan_out), int'(e));
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("scan wrap", int'(scan_out), 4'b1110);
      chk_outs("idle frame", 0, 0, 0, 0, 0);
      foreach (tv[i]) begin
         keys = tv[i].keys;
         run_frames(1);
         chk_outs($sformatf("step%0d", i), tv[i].pulses, tv[i].valid, tv[i].held, tv[i].merr, tv[i].code);
      end
      keys = 16'h0200;
      run_frames(1);
      chk("mid-rst pre pulses", pulses, 6);
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("mid-rst scan_out", int'(scan_out), 4'b1110);
      chk("mid-rst key_code", int'(key_code), 0);
      chk("mid-rst key_held", int'(key_held), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_frames(1);
      chk_outs("post-rst frame1", 6, 0, 0, 0, 0);
      run_frames(1);
      chk_outs("post-rst frame2", 7, 1, 1, 0, 9);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
